// File: rtl/fetch_unit.sv
// Instruction fetch: PC register, 3-state request FSM, FQ_DEPTH-entry queue to decode; FETCH_MISALIGN_CHECK_EN adds misalign_d.
// Latency: first instruction valid 3 cycles after reset release (gnt=1, 1-cycle rvalid); 1 instr/cycle steady state.
// Backpressure: ready_d low holds the head; requests stop once queued + outstanding reaches FQ_DEPTH.
module fetch_unit #(
    parameter int              XLEN     = 64,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              FQ_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req,
    output logic [XLEN-3:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    output logic            valid_d,
    input  logic            ready_d,
    output logic [31:0]     instr_d,
    output logic [XLEN-1:0] pc_d,
    output logic [XLEN-1:0] pc_plus4_d
`ifdef FETCH_MISALIGN_CHECK_EN
    ,
    output logic            misalign_d
`endif
);

    localparam int PTR_W = $clog2(FQ_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [XLEN-1:0]   pcf_q;
    logic [XLEN-1:0]   req_pc_q;
    logic              req_epoch_q;
    logic              epoch_q;

    logic [31:0]       fq_instr [FQ_DEPTH];
    logic [XLEN-1:0]   fq_pc    [FQ_DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q, wr_ptr_q;
    logic [CNT_W-1:0]  count_q;

    logic              outstanding;
    logic              rsp_fire;
    logic              pop;
    logic              push;
    logic              grant;
    logic [CNT_W:0]    committed;
    logic              halt;
    logic              redir_mis;
    logic [XLEN-1:0]   redir_pc;

`ifdef FETCH_MISALIGN_CHECK_EN
    logic              halt_q;
    logic              fq_mis [FQ_DEPTH];

    assign halt      = halt_q;
    assign redir_mis = redirect_valid && (redirect_pc[1:0] != 2'b00);
    assign redir_pc  = redirect_pc;
`else
    logic              unused_redir_lsb;

    assign halt             = 1'b0;
    assign redir_mis        = 1'b0;
    assign redir_pc         = {redirect_pc[XLEN-1:2], 2'b00};
    assign unused_redir_lsb = ^redirect_pc[1:0];
`endif

    assign outstanding = (state_q == S_WAIT);
    assign rsp_fire    = outstanding && imem_rvalid;
    assign valid_d     = (count_q != '0);
    assign pop         = valid_d && ready_d;
    assign imem_addr   = pcf_q[XLEN-1:2];

    // Entries already queued plus the one in flight, less the one leaving this cycle.
    assign committed = {1'b0, count_q} + (CNT_W+1)'(outstanding) - (CNT_W+1)'(pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        imem_req = 1'b0;
        grant    = 1'b0;
        push     = 1'b0;
        case (state_q)
            S_IDLE: begin
                state_d = S_FETCH;
            end
            S_FETCH: begin
                imem_req = !redirect_valid && !halt && (committed < (CNT_W+1)'(FQ_DEPTH));
                grant    = imem_req && imem_gnt;
                if (grant) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    imem_req = !redirect_valid && !halt && (committed < (CNT_W+1)'(FQ_DEPTH));
                    grant    = imem_req && imem_gnt;
                    push     = !redirect_valid && (req_epoch_q == epoch_q);
                    state_d  = grant ? S_WAIT : S_FETCH;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcf_q       <= RESET_PC;
            req_pc_q    <= '0;
            req_epoch_q <= 1'b0;
            epoch_q     <= 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
            halt_q      <= 1'b0;
`endif
        end else if (redirect_valid) begin
            pcf_q       <= redir_pc;
            epoch_q     <= ~epoch_q;
            // Tag any in-flight request with the old epoch so it mismatches even after repeated redirects.
            req_epoch_q <= epoch_q;
`ifdef FETCH_MISALIGN_CHECK_EN
            halt_q      <= redir_mis;
`endif
        end else if (grant) begin
            pcf_q       <= pcf_q + XLEN'(4);
            req_pc_q    <= pcf_q;
            req_epoch_q <= epoch_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < FQ_DEPTH; i++) begin
                fq_instr[i] <= '0;
                fq_pc[i]    <= '0;
`ifdef FETCH_MISALIGN_CHECK_EN
                fq_mis[i]   <= 1'b0;
`endif
            end
        end else if (redirect_valid) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
`ifdef FETCH_MISALIGN_CHECK_EN
            // A misaligned target becomes a single marker entry instead of a fetch.
            if (redir_mis) begin
                fq_instr[0] <= '0;
                fq_pc[0]    <= redirect_pc;
                fq_mis[0]   <= 1'b1;
                wr_ptr_q    <= PTR_W'(1);
                count_q     <= CNT_W'(1);
            end
`endif
        end else begin
            if (push) begin
                fq_instr[wr_ptr_q] <= imem_rdata;
                fq_pc[wr_ptr_q]    <= req_pc_q;
`ifdef FETCH_MISALIGN_CHECK_EN
                fq_mis[wr_ptr_q]   <= 1'b0;
`endif
                wr_ptr_q           <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Head fields read as zero whenever the queue is empty, including straight out of reset.
    assign instr_d    = valid_d ? fq_instr[rd_ptr_q] : '0;
    assign pc_d       = valid_d ? fq_pc[rd_ptr_q] : '0;
    assign pc_plus4_d = valid_d ? (fq_pc[rd_ptr_q] + XLEN'(4)) : '0;
`ifdef FETCH_MISALIGN_CHECK_EN
    assign misalign_d = valid_d && fq_mis[rd_ptr_q];
`endif

endmodule
